// File: rtl/ring_noc_pkg.sv
// Packet format and width constants shared by the ring interconnect.
package NetworkPkg;

  localparam int NODE_ID_W = 8;   // bounds the ring at 256 stops
  localparam int HOPS_W    = 8;
  localparam int BRT_W     = 4;
  localparam int ADDR_W    = 64;

  typedef struct packed {
    logic [NODE_ID_W-1:0] dest;
    logic [NODE_ID_W-1:0] src;
    logic [HOPS_W-1:0]    hops;
    logic [BRT_W-1:0]     brt;
    logic [ADDR_W-1:0]    addr;
  } pkt_t;

endpackage

// File: rtl/ring_inj_fifo.sv
// Per-node injection FIFO: circular buffer with a registered occupancy count.
// Full/empty are decoded from the registered count only, so a full FIFO is
// reported full even on a cycle in which it pops.
module ring_inj_fifo
  import NetworkPkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  pkt_t din_i,
  input  logic pop_i,
  output pkt_t head_o,
  output logic full_o,
  output logic empty_o
);

  pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; reset discards all queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ring_noc.sv
// Unidirectional ring interconnect: one injection FIFO and one link register
// per stop. Ring traffic always wins over injection; packets never stall once
// on the ring. Optional per-node delivery counters are built only when
// RING_STATS_EN is defined; otherwise delivered_cnt is tied to zero.
module ring_noc
  import NetworkPkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int INJ_DEPTH = 4,
  localparam int IF_W = $clog2(NUM_NODES * (INJ_DEPTH + 1) + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pkt_t [NUM_NODES-1:0]       pkt_in,
  input  logic [NUM_NODES-1:0]       pkt_in_valid,
  output logic [NUM_NODES-1:0]       pkt_in_ready,
  output pkt_t [NUM_NODES-1:0]       pkt_out,
  output logic [NUM_NODES-1:0]       pkt_out_valid,
  output logic                       dest_err,
  output logic [IF_W-1:0]            in_flight,
  output logic [NUM_NODES-1:0][31:0] delivered_cnt
);

  pkt_t                 ring_pkt [NUM_NODES];
  logic [NUM_NODES-1:0] ring_vld;
  logic [NUM_NODES-1:0] acc_vec;
  logic [NUM_NODES-1:0] bad_vec;
  logic [NUM_NODES-1:0] ej_vec;
  logic [IF_W-1:0]      acc_cnt;
  logic [IF_W-1:0]      ej_cnt;
  logic [IF_W-1:0]      in_flight_q;
  logic [IF_W-1:0]      in_flight_d;
  logic                 dest_err_q;

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
    localparam int PREV = (gi + NUM_NODES - 1) % NUM_NODES;

    logic legal;
    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic eject;
    logic fwd;
    logic pop;
    pkt_t push_pkt;
    pkt_t head_pkt;
    pkt_t in_pkt;
    logic slot_vld_q;
    logic slot_vld_d;
    pkt_t slot_q;
    pkt_t slot_d;
    logic out_vld_q;
    pkt_t out_q;

    assign in_pkt = ring_pkt[PREV];
    assign legal  = ({24'd0, pkt_in[gi].dest} < 32'(NUM_NODES));
    assign accept = pkt_in_valid[gi] && !fifo_full;

    // Stamp the source id and clear the hop count on entry.
    always_comb begin
      push_pkt      = pkt_in[gi];
      push_pkt.src  = NODE_ID_W'(gi);
      push_pkt.hops = '0;
    end

    ring_inj_fifo #(.DEPTH(INJ_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (accept && legal),
      .din_i  (push_pkt),
      .pop_i  (pop),
      .head_o (head_pkt),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
    );

    assign eject = ring_vld[PREV] && (in_pkt.dest == NODE_ID_W'(gi));
    assign fwd   = ring_vld[PREV] && !eject;
    assign pop   = !fwd && !fifo_empty;

    // Link arbitration: pass-through first, then the FIFO head, else empty.
    always_comb begin
      slot_vld_d = 1'b0;
      slot_d     = '0;
      if (fwd) begin
        slot_vld_d  = 1'b1;
        slot_d      = in_pkt;
        slot_d.hops = in_pkt.hops + HOPS_W'(1);
      end else if (pop) begin
        slot_vld_d  = 1'b1;
        slot_d      = head_pkt;
        slot_d.hops = HOPS_W'(1);
      end
    end

    // Link register and registered delivery port.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_vld_q <= 1'b0;
        slot_q     <= '0;
        out_vld_q  <= 1'b0;
        out_q      <= '0;
      end else begin
        slot_vld_q <= slot_vld_d;
        slot_q     <= slot_d;
        out_vld_q  <= eject;
        if (eject) out_q <= in_pkt;
      end
    end

    assign ring_pkt[gi]      = slot_q;
    assign ring_vld[gi]      = slot_vld_q;
    assign pkt_out[gi]       = out_q;
    assign pkt_out_valid[gi] = out_vld_q;
    assign pkt_in_ready[gi]  = !fifo_full;
    assign acc_vec[gi]       = accept && legal;
    assign bad_vec[gi]       = accept && !legal;
    assign ej_vec[gi]        = eject;

`ifdef RING_STATS_EN
    logic [31:0] dcnt_q;

    // Delivery counter advances with the ejection that raises the pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dcnt_q <= '0;
      else if (eject) dcnt_q <= dcnt_q + 32'd1;
    end

    assign delivered_cnt[gi] = dcnt_q;
`else
    assign delivered_cnt[gi] = '0;
`endif
  end

  // Ring-wide accept/eject tallies for the in-flight counter.
  always_comb begin
    acc_cnt = '0;
    ej_cnt  = '0;
    for (int k = 0; k < NUM_NODES; k++) begin
      acc_cnt = acc_cnt + IF_W'(acc_vec[k]);
      ej_cnt  = ej_cnt + IF_W'(ej_vec[k]);
    end
    in_flight_d = in_flight_q + acc_cnt - ej_cnt;
  end

  // In-flight counter and sticky bad-destination flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
      dest_err_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      dest_err_q  <= dest_err_q | (|bad_vec);
    end
  end

  assign in_flight = in_flight_q;
  assign dest_err  = dest_err_q;

endmodule

// File: tb/tb_ring_noc.sv
// Directed bench for ring_noc (N=4, INJ_DEPTH=4).
module tb_ring_noc;
  import NetworkPkg::*;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int IF_W = $clog2(N * (D + 1) + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  pkt_t [N-1:0]        pkt_in;
  logic [N-1:0]        pkt_in_valid;
  logic [N-1:0]        pkt_in_ready;
  pkt_t [N-1:0]        pkt_out;
  logic [N-1:0]        pkt_out_valid;
  logic                dest_err;
  logic [IF_W-1:0]     in_flight;
  logic [N-1:0][31:0]  delivered_cnt;

  int checks = 0;
  int errors = 0;
  int tag = 16;
  int accepted = 0;
  int delivered = 0;
  int pulses [N];
  int exp_dcnt [N];
  bit outstanding [256];
  int n0_acc;
  int late_pulses;
  bit a0;
  bit a3;

  always #5 clk = ~clk;

  ring_noc #(.NUM_NODES(N), .INJ_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_in       (pkt_in),
    .pkt_in_valid (pkt_in_valid),
    .pkt_in_ready (pkt_in_ready),
    .pkt_out      (pkt_out),
    .pkt_out_valid(pkt_out_valid),
    .dest_err     (dest_err),
    .in_flight    (in_flight),
    .delivered_cnt(delivered_cnt)
  );

  task automatic chk(string tg, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  function automatic pkt_t mk(int dest, int addr);
    pkt_t p;
    p.dest = 8'(dest);
    p.src  = 8'hAA;
    p.hops = 8'h55;
    p.brt  = 4'h9;
    p.addr = 64'(addr);
    return p;
  endfunction

  function automatic logic [63:0] exp_dc(int i);
`ifdef RING_STATS_EN
    return 64'(exp_dcnt[i]);
`else
    return 64'(i - i);
`endif
  endfunction

  // Offer a tagged packet on node i; record it if the FIFO will take it.
  task automatic offer_set(int i, int dest, output bit acc);
    pkt_in[i] = mk(dest, tag);
    acc = pkt_in_ready[i];
    if (acc) begin
      outstanding[tag] = 1'b1;
      accepted++;
      exp_dcnt[dest]++;
    end
    tag++;
  endtask

  // Score every delivery visible this cycle against the outstanding set.
  task automatic collect();
    for (int i = 0; i < N; i++) begin
      if (pkt_out_valid[i]) begin
        int s;
        int a;
        s = int'(pkt_out[i].src);
        a = int'(pkt_out[i].addr[7:0]);
        chk("deliv_dest", 64'(pkt_out[i].dest), 64'(i));
        chk("deliv_hops", 64'(pkt_out[i].hops), 64'((((i - s - 1) % N) + N) % N + 1));
        chk("deliv_tag", 64'(outstanding[a]), 64'd1);
        outstanding[a] = 1'b0;
        delivered++;
        pulses[i]++;
      end
    end
  endtask

  initial begin
    pkt_in       = '0;
    pkt_in_valid = '0;
    for (int i = 0; i < N; i++) begin
      pulses[i]   = 0;
      exp_dcnt[i] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(pkt_in_ready), 64'hF);
    chk("rst_valid", 64'(pkt_out_valid), 64'h0);
    chk("rst_inflight", 64'(in_flight), 64'h0);
    chk("rst_dest_err", 64'(dest_err), 64'h0);
    chk("rst_dcnt", 64'(|delivered_cnt), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: src 1 -> dest 3, 2 hops, pulse 3 edges after acceptance
    pkt_in[1]    = mk(3, 'h1111);
    pkt_in_valid = 4'b0010;
    @(negedge clk);
    pkt_in_valid = '0;
    exp_dcnt[3]++;
    chk("t1_inflight_acc", 64'(in_flight), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t1_valid", 64'(pkt_out_valid), (k == 3) ? 64'h8 : 64'h0);
      chk("t1_inflight", 64'(in_flight), (k == 3) ? 64'd0 : 64'd1);
    end
    chk("t1_dest", 64'(pkt_out[3].dest), 64'd3);
    chk("t1_src", 64'(pkt_out[3].src), 64'd1);
    chk("t1_hops", 64'(pkt_out[3].hops), 64'd2);
    chk("t1_brt", 64'(pkt_out[3].brt), 64'h9);
    chk("t1_addr", pkt_out[3].addr, 64'h1111);
    @(negedge clk);
    chk("t1_pulse_end", 64'(pkt_out_valid), 64'h0);

    // T2: src 2 -> dest 2 circles the whole ring
    pkt_in[2]    = mk(2, 'h2222);
    pkt_in_valid = 4'b0100;
    @(negedge clk);
    pkt_in_valid = '0;
    exp_dcnt[2]++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t2_valid", 64'(pkt_out_valid), (k == 5) ? 64'h4 : 64'h0);
    end
    chk("t2_hops", 64'(pkt_out[2].hops), 64'd4);
    chk("t2_src", 64'(pkt_out[2].src), 64'd2);
    chk("t2_inflight", 64'(in_flight), 64'd0);

    // T3: every node sends to (i+2) mod 4 for 20 cycles
    accepted  = 0;
    delivered = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        bit acc;
        offer_set(i, (i + 2) % N, acc);
      end
      pkt_in_valid = '1;
      @(negedge clk);
      collect();
    end
    pkt_in_valid = '0;
    for (int c = 0; c < 100 && in_flight != 0; c++) begin
      @(negedge clk);
      collect();
    end
    chk("t3_inflight", 64'(in_flight), 64'd0);
    chk("t3_count", 64'(delivered), 64'(accepted));
    for (int i = 0; i < N; i++) chk("t3_dcnt", 64'(delivered_cnt[i]), exp_dc(i));

    // T4: node 3 streams to node 2 through node 0 while node 0 queues
    for (int i = 0; i < N; i++) pulses[i] = 0;
    accepted     = 0;
    delivered    = 0;
    pkt_in_valid = 4'b1000;
    offer_set(3, 2, a3);
    @(negedge clk);
    collect();
    offer_set(3, 2, a3);
    @(negedge clk);
    collect();
    n0_acc = 0;
    for (int c = 0; c < 8; c++) begin
      offer_set(3, 2, a3);
      offer_set(0, 1, a0);
      if (a0) n0_acc++;
      pkt_in_valid = 4'b1001;
      @(negedge clk);
      collect();
    end
    chk("t4_n0_accepts", 64'(n0_acc), 64'd4);
    chk("t4_ready0", 64'(pkt_in_ready[0]), 64'd0);
    chk("t4_no_inject_busy", 64'(pulses[1]), 64'd0);
    chk("t4_inflight_mid", 64'(in_flight), 64'(accepted - delivered));
    pkt_in_valid = '0;
    for (int c = 0; c < 100 && in_flight != 0; c++) begin
      @(negedge clk);
      collect();
    end
    chk("t4_n1_deliv", 64'(pulses[1]), 64'd4);
    chk("t4_count", 64'(delivered), 64'(accepted));
    chk("t4_inflight", 64'(in_flight), 64'd0);
    for (int i = 0; i < N; i++) chk("t4_dcnt", 64'(delivered_cnt[i]), exp_dc(i));

    // T5: illegal destination is dropped and flagged
    pkt_in[1]    = mk(7, 'h7777);
    pkt_in_valid = 4'b0010;
    @(negedge clk);
    pkt_in_valid = '0;
    chk("t5_dest_err", 64'(dest_err), 64'd1);
    chk("t5_inflight", 64'(in_flight), 64'd0);
    late_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      late_pulses += $countones(pkt_out_valid);
    end
    chk("t5_no_deliv", 64'(late_pulses), 64'd0);
    chk("t5_dest_err_sticky", 64'(dest_err), 64'd1);
    chk("t5_ready", 64'(pkt_in_ready), 64'hF);

    // T6: asynchronous reset with three packets on the ring
    pkt_in[0]    = mk(0, 'hA0);
    pkt_in[1]    = mk(1, 'hA1);
    pkt_in[2]    = mk(2, 'hA2);
    pkt_in_valid = 4'b0111;
    @(negedge clk);
    pkt_in_valid = '0;
    @(negedge clk);
    chk("t6_inflight_pre", 64'(in_flight), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("t6_inflight", 64'(in_flight), 64'd0);
    chk("t6_dest_err", 64'(dest_err), 64'd0);
    chk("t6_ready", 64'(pkt_in_ready), 64'hF);
    chk("t6_valid", 64'(pkt_out_valid), 64'h0);
    chk("t6_pkt_out", 64'(|pkt_out), 64'd0);
    chk("t6_dcnt", 64'(|delivered_cnt), 64'd0);
    late_pulses = 0;
    repeat (3) begin
      @(negedge clk);
      late_pulses += $countones(pkt_out_valid);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      late_pulses += $countones(pkt_out_valid);
    end
    chk("t6_no_deliv", 64'(late_pulses), 64'd0);
    chk("t6_inflight_post", 64'(in_flight), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
